// File: rtl/rams_port_if.sv
// One requester's view of the shared RAM port: request handshake plus read-return signals.
// The requester drives the master side and the arbiter drives the slave side.
interface rams_port_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/rams_port_arbiter.sv
// Shares one single-port, registered-read BRAM between requesters A and B.
// The winning request is registered onto the RAM port; read data returns through a 2-stage owner tag.
module rams_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rams_port_if.slave        a,
  rams_port_if.slave        b,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
  localparam bit   RR    = (RR_EN != 0);

  logic              ptr;
  logic              contested;
  logic              grant_a;
  logic              grant_b;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              tag1_vld;
  logic              tag1_own;
  logic              tag2_vld;
  logic              tag2_own;

  // Grant is combinational so ready can follow valid within the same cycle.
  always_comb begin
    contested = a.valid && b.valid;
    grant_a   = a.valid && (!b.valid || !RR || (ptr == OWN_A));
    grant_b   = b.valid && !grant_a;
    grant     = grant_a || grant_b;
    sel_we    = grant_a ? a.we    : b.we;
    sel_addr  = grant_a ? a.addr  : b.addr;
    sel_wdata = grant_a ? a.wdata : b.wdata;
  end

  assign a.ready = grant_a;
  assign b.ready = grant_b;

  // Only a contested grant moves the pointer, so a lone requester cannot steal the next turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= OWN_A;
    end else if (RR && contested) begin
      ptr <= grant_a ? OWN_B : OWN_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_we <= grant && sel_we;
      if (grant) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_wdata;
      end
    end
  end

  // Stage 1 lines up with the RAM sampling the address, stage 2 with ram_dout being valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_vld <= 1'b0;
      tag1_own <= OWN_A;
      tag2_vld <= 1'b0;
      tag2_own <= OWN_A;
    end else begin
      tag1_vld <= grant && !sel_we;
      tag1_own <= grant_b ? OWN_B : OWN_A;
      tag2_vld <= tag1_vld;
      tag2_own <= tag1_own;
    end
  end

  assign a.rvalid = tag2_vld && (tag2_own == OWN_A);
  assign b.rvalid = tag2_vld && (tag2_own == OWN_B);
  assign a.rdata  = ram_dout;
  assign b.rdata  = ram_dout;
endmodule
